// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: D = a - b, B = borrow out, one bit per clock.
// Optional signed overflow flag (port ovf) is built when SERSUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             d;
  logic             bo;
  logic             last;
  logic [WIDTH-1:0] shifted;

  assign x       = sa[0];
  assign y       = sb[0];
  assign d       = x ^ y ^ br;
  assign bo      = (~x & y) | (~(x ^ y) & br);
  assign last    = (cnt == CW'(WIDTH - 1));
  // sr keeps only the upper WIDTH-1 collected bits; the new bit enters at the top
  assign shifted = {d, sr};

`ifdef SERSUB_OVF_EN
  logic am;
  logic bm;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      B     <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
`ifdef SERSUB_OVF_EN
      ovf   <= 1'b0;
      am    <= 1'b0;
      bm    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
`ifdef SERSUB_OVF_EN
            am    <= a[WIDTH-1];
            bm    <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= shifted[WIDTH-1:1];
          br  <= bo;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            D     <= shifted;
            B     <= bo;
`ifdef SERSUB_OVF_EN
            ovf   <= (am != bm) && (d != am);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vectors plus exhaustive WIDTH=2.
// Ovf checks are built when SERSUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] D;
  logic       B;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2;
  logic       done2;
  logic [1:0] D2;
  logic       B2;

`ifdef SERSUB_OVF_EN
  logic       ovf;
  logic       ovf2;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_d;
  logic       prev_b;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .D    (D),
    .B    (B)
`ifdef SERSUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(2)) u2 (
    .clk  (clk),
    .rst  (rst),
    .start(start2),
    .a    (a2),
    .b    (b2),
    .busy (busy2),
    .done (done2),
    .D    (D2),
    .B    (B2)
`ifdef SERSUB_OVF_EN
    ,
    .ovf  (ovf2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation; hold keeps start high for a back-to-back run.
  task automatic op8(input string tag, input logic [7:0] x,
                     input logic [7:0] y, input logic [7:0] ed,
                     input logic eb, input logic eo, input logic hold);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      chk({tag, "_hold_d"}, {24'd0, D}, {24'd0, prev_d});
      chk({tag, "_hold_b"}, {31'd0, B}, {31'd0, prev_b});
      a = ~a;
      b = b + 8'h35;
      tick();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_notbusy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_d"}, {24'd0, D}, {24'd0, ed});
    chk({tag, "_b"}, {31'd0, B}, {31'd0, eb});
`ifdef SERSUB_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo) begin end
`endif
    prev_d = ed;
    prev_b = eb;
    if (!hold) begin
      tick();
      chk({tag, "_pulse_end"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_keep_d"}, {24'd0, D}, {24'd0, ed});
    end
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] ed;
    logic       eb;
    ed     = x - y;
    eb     = (x < y);
    a2     = x;
    b2     = y;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("w2_busy", {31'd0, busy2}, 32'd1);
      chk("w2_nodone", {31'd0, done2}, 32'd0);
      a2 = ~a2;
      tick();
    end
    chk("w2_done", {31'd0, done2}, 32'd1);
    chk("w2_d", {30'd0, D2}, {30'd0, ed});
    chk("w2_b", {31'd0, B2}, {31'd0, eb});
    tick();
    chk("w2_pulse_end", {31'd0, done2}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start2 = 1'b0;
    a2     = '0;
    b2     = '0;
    prev_d = '0;
    prev_b = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_d", {24'd0, D}, 32'd0);
    chk("rst_b", {31'd0, B}, 32'd0);
`ifdef SERSUB_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    op8("s05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    op8("s03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    op8("s00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // back-to-back: start stays high through DONE
    op8("b2b_1", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1);
    op8("b2b_2", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1);
    op8("b2b_3", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a run
    a     = 8'h55;
    b     = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_d", {24'd0, D}, 32'd0);
    chk("mid_rst_b", {31'd0, B}, 32'd0);
    prev_d = '0;
    prev_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("mid_rst_nodone", {31'd0, done}, 32'd0);
      tick();
    end
    op8("s10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);

    op8("o80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8("o7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    op8("o05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        op2(2'(i), 2'(j));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
